cpu_core_q: RTL

Parametrised multicycle successor to the 16-bit teaching CPU: same 16-bit ISA (MOV imm, MOV shift, ADD, CMP, AND, MVN), with a configurable datapath width and an instruction queue that lets the host load several instructions and run them back-to-back on one start pulse. It sits where the single-instruction CPU sits today, driven by the same `s`/`load`/`in` host interface, and adds a `full` output.

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/cpu_iq.sv | 64 ++++++
 rtl/cpu_core_q.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the queued multicycle CPU.
// Holds the opcode/op encodings, shift-code and FSM state enums, and
// helpers that slice fields out of a 16-bit instruction word.
// No ports (package).
package cpu_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVS = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_GETA   = 3'd3,
    S_GETB   = 3'd4,
    S_EXEC   = 3'd5,
    S_WRITE  = 3'd6
  } state_e;

  function automatic logic [2:0] f_opcode(input logic [15:0] i);
    return i[15:13];
  endfunction

  function automatic logic [1:0] f_op(input logic [15:0] i);
    return i[12:11];
  endfunction

  function automatic logic [2:0] f_rn(input logic [15:0] i);
    return i[10:8];
  endfunction

  function automatic logic [2:0] f_rd(input logic [15:0] i);
    return i[7:5];
  endfunction

  function automatic shift_e f_sh(input logic [15:0] i);
    return shift_e'(i[4:3]);
  endfunction

  function automatic logic [2:0] f_rm(input logic [15:0] i);
    return i[2:0];
  endfunction

  function automatic logic [7:0] f_imm8(input logic [15:0] i);
    return i[7:0];
  endfunction

endpackage

// File: rtl/cpu_iq.sv
// cpu_iq: QDEPTH x 16-bit instruction FIFO.
// Ports: clk, reset (async, active-high), push/din (ignored while full),
//        pop (ignored while empty), dout (head word), empty, full.
// Pointers wrap naturally because QDEPTH is a power of two.
module cpu_iq #(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [15:0] din,
  input  logic        pop,
  output logic [15:0] dout,
  output logic        empty,
  output logic        full
);
  import cpu_pkg::*;

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(QDEPTH));
  assign dout    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a flushed queue never exposes stale words.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cpu_core_q.sv
// cpu_core_q: multicycle 16-bit-ISA CPU with configurable datapath width
// and an instruction queue so several loaded words run on one start pulse.
// Ports: clk, reset (async, active-high), s (start, sampled in S_WAIT),
//        load/in (push instruction word), out (result register C),
//        N/V/Z (flags from last CMP), w (idle), full (queue full).
// Optional feature macro CPU_CARRY_EN: adds output C, the CMP carry-out
// (1 = no borrow). Without it there is no C port and no carry logic.
module cpu_core_q #(
  parameter int DATA_W = 16,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [15:0]       in,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              w,
  output logic              full
`ifdef CPU_CARRY_EN
  ,
  output logic              C
`endif
);
  import cpu_pkg::*;

  function automatic logic [DATA_W-1:0] shift_op(input logic [DATA_W-1:0] v,
                                                 input shift_e sh);
    case (sh)
      SH_LSL:  return {v[DATA_W-2:0], 1'b0};
      SH_LSR:  return {1'b0, v[DATA_W-1:1]};
      SH_ASR:  return {v[DATA_W-1], v[DATA_W-1:1]};
      default: return v;
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] sext8(input logic signed [7:0] imm);
    return DATA_W'(imm);
  endfunction

  state_e             state_q, state_d;
  logic [15:0]        ir_q, ir_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic               n_q, n_d, v_q, v_d, z_q, z_d;
  logic [DATA_W-1:0]  regs [8];

  logic               wr_en;
  logic [2:0]         wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               iq_pop, iq_empty, iq_full;
  logic [15:0]        iq_dout;
  state_e             next_instr;

  logic signed [DATA_W-1:0] a_s, shb_s, diff_s;
  logic        [DATA_W-1:0] shb;

`ifdef CPU_CARRY_EN
  logic              carry_q, carry_d;
  logic [DATA_W:0]   cmp_wide;
`endif

  cpu_iq #(.QDEPTH(QDEPTH)) u_iq (
    .clk   (clk),
    .reset (reset),
    .push  (load),
    .din   (in),
    .pop   (iq_pop),
    .dout  (iq_dout),
    .empty (iq_empty),
    .full  (iq_full)
  );

  // Shifter and subtractor feeding S_EXEC
  always_comb begin
    shb    = shift_op(b_q, f_sh(ir_q));
    a_s    = a_q;
    shb_s  = shb;
    diff_s = a_s - shb_s;
  end

`ifdef CPU_CARRY_EN
  assign cmp_wide = {1'b0, a_q} + {1'b0, ~shb} + {{DATA_W{1'b0}}, 1'b1};
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    n_d     = n_q;
    v_d     = v_q;
    z_d     = z_q;
    wr_en   = 1'b0;
    wr_addr = f_rd(ir_q);
    wr_data = out_q;
    iq_pop  = 1'b0;
`ifdef CPU_CARRY_EN
    carry_d = carry_q;
`endif
    // Back-to-back sequencing: the next queued word starts without an idle cycle.
    next_instr = iq_empty ? S_WAIT : S_FETCH;

    case (state_q)
      S_WAIT: begin
        if (s && !iq_empty) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = iq_dout;
        iq_pop  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (f_opcode(ir_q) == OPC_MOV && f_op(ir_q) == OP_MOVI)      state_d = S_WRITE;
        else if (f_opcode(ir_q) == OPC_MOV && f_op(ir_q) == OP_MOVS) state_d = S_GETB;
        else if (f_opcode(ir_q) == OPC_ALU)                           state_d = S_GETA;
        else                                                          state_d = next_instr;
      end
      S_GETA: begin
        a_d     = regs[f_rn(ir_q)];
        state_d = S_GETB;
      end
      S_GETB: begin
        b_d     = regs[f_rm(ir_q)];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (f_opcode(ir_q) == OPC_MOV) begin
          out_d   = shb;
          state_d = S_WRITE;
        end else begin
          case (f_op(ir_q))
            OP_ADD: out_d = a_q + shb;
            OP_AND: out_d = a_q & shb;
            OP_MVN: out_d = ~shb;
            default: begin
              z_d = (diff_s == '0);
              n_d = diff_s[DATA_W-1];
              v_d = (a_s[DATA_W-1] != shb_s[DATA_W-1]) &&
                    (diff_s[DATA_W-1] != a_s[DATA_W-1]);
`ifdef CPU_CARRY_EN
              carry_d = cmp_wide[DATA_W];
`endif
            end
          endcase
          state_d = (f_op(ir_q) == OP_CMP) ? next_instr : S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        // MOV imm bypasses the result register so out stays unchanged.
        if (f_opcode(ir_q) == OPC_MOV && f_op(ir_q) == OP_MOVI) begin
          wr_addr = f_rn(ir_q);
          wr_data = sext8(f_imm8(ir_q));
        end
        state_d = next_instr;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
`ifdef CPU_CARRY_EN
      carry_q <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
`ifdef CPU_CARRY_EN
      carry_q <= carry_d;
`endif
      if (wr_en) regs[wr_addr] <= wr_data;
    end
  end

  assign out  = out_q;
  assign N    = n_q;
  assign V    = v_q;
  assign Z    = z_q;
  assign w    = (state_q == S_WAIT);
  assign full = iq_full;
`ifdef CPU_CARRY_EN
  assign C    = carry_q;
`endif

endmodule
